pin_mux_host: RTL

PIN_MUX_HOST -- requirements
Module: pin_mux_host

---
 rtl/pin_mux_host.sv | 93 +++++++++
 1 files changed

// File: rtl/pin_mux_host.sv
// Host-side sequencer for a pin-muxed chip: drives ui/uio pins,
// waits a settle window, then samples uo into a valid/ready response.
module pin_mux_host #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_sel,
    input  logic [5:0] req_a,
    input  logic [5:0] req_b,
    input  logic       req_cin,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [1:0] rsp_sel,
    output logic [7:0] pin_ui,
    output logic [7:0] pin_uio,
    input  logic [7:0] pin_uo,
    output logic       busy,
    output logic [7:0] txn_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t     state;
    logic [3:0] cnt;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            pin_ui    <= 8'd0;
            pin_uio   <= 8'd0;
            rsp_data  <= 8'd0;
            rsp_err   <= 1'b0;
            rsp_sel   <= 2'd0;
            txn_count <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!req_sel[1]) begin
                            pin_ui  <= {req_sel, req_a};
                            pin_uio <= {req_cin, 1'b0, req_b};
                            cnt     <= SETTLE_LD;
                            state   <= SETTLE;
                        end else begin
                            // reserved channel: pins untouched so chip state survives
                            rsp_data <= 8'd0;
                            rsp_err  <= 1'b1;
                            rsp_sel  <= req_sel;
                            state    <= RESP;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd1) begin
                        rsp_data <= pin_uo;
                        rsp_err  <= 1'b0;
                        rsp_sel  <= pin_ui[7:6];
                        cnt      <= 4'd0;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                        if (!rsp_err) begin
                            txn_count <= txn_count + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
